// File: rtl/bram_burst_master.sv
// Burst master for a single-port block RAM with one-cycle read latency.
// Write bursts stream from wr_*; read bursts stream out through a 4-deep FIFO.
module bram_burst_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  bram_en,
    output logic                  bram_wen,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_datai,
    input  logic [DATA_WIDTH-1:0] bram_datao,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  en_q;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] baddr_q;
    logic [DATA_WIDTH-1:0] bdata_q;
    logic                  wr_done_q;
    logic                  rd_iss_q;
    logic                  rd_cap_q;

    logic [DATA_WIDTH-1:0] fifo_q [4];
    logic [1:0]            wptr_q;
    logic [1:0]            rptr_q;
    logic [2:0]            occ_q;

    logic       cmd_hs;
    logic       wr_hs;
    logic       rd_issue;
    logic       rd_pop;
    logic       last_word;
    logic       no_flight;
    logic       final_pop;
    logic [2:0] pend;

    assign last_word  = (cnt_q == '0);
    assign no_flight  = !rd_iss_q && !rd_cap_q;
    assign pend       = occ_q + 3'(rd_iss_q) + 3'(rd_cap_q);
    assign bram_en    = en_q;
    assign bram_wen   = wen_q;
    assign bram_addr  = baddr_q;
    assign bram_datai = bdata_q;
    assign rd_data    = fifo_q[rptr_q];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: write ends on last handshake, read drains after last issue
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_hs) begin
                    state_d = cmd_write ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_hs && last_word) begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (rd_issue && last_word) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (occ_q == 3'd0 && no_flight) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshakes and status; a read is issued only if it can never overflow the FIFO
    always_comb begin
        cmd_ready = (state_q == IDLE) && !reset;
        wr_ready  = (state_q == WRITE) && !reset;
        busy      = (state_q != IDLE) && !reset;
        rd_valid  = (occ_q != 3'd0) && !reset;
        cmd_hs    = cmd_valid && cmd_ready;
        wr_hs     = wr_valid && wr_ready;
        rd_issue  = (state_q == READ) && (pend < 3'd4) && !reset;
        rd_pop    = rd_valid && rd_ready;
        final_pop = (state_q == DRAIN) && rd_pop
                    && (occ_q == 3'd1) && no_flight;
        done      = !reset && (wr_done_q || final_pop);
    end

    // Address/length counters and registered BRAM port
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
            wen_q     <= 1'b0;
            baddr_q   <= '0;
            bdata_q   <= '0;
            wr_done_q <= 1'b0;
            rd_iss_q  <= 1'b0;
            rd_cap_q  <= 1'b0;
        end else begin
            en_q      <= wr_hs || rd_issue;
            wen_q     <= wr_hs;
            wr_done_q <= wr_hs && last_word;
            rd_iss_q  <= rd_issue;
            rd_cap_q  <= rd_iss_q;
            if (cmd_hs) begin
                addr_q <= cmd_addr;
                cnt_q  <= cmd_len;
            end else if (wr_hs || rd_issue) begin
                baddr_q <= addr_q;
                addr_q  <= addr_q + 1'b1;
                cnt_q   <= cnt_q - 1'b1;
            end
            if (wr_hs) begin
                bdata_q <= wr_data;
            end
        end
    end

    // FIFO pointers and occupancy; capture and pop may coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            if (rd_cap_q) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (rd_pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            occ_q <= occ_q + 3'(rd_cap_q) - 3'(rd_pop);
        end
    end

    // FIFO storage: capture read data one cycle after the port read
    always_ff @(posedge clk) begin
        if (rd_cap_q) begin
            fifo_q[wptr_q] <= bram_datao;
        end
    end

endmodule

// File: tb/tb_bram_burst_master.sv
// Scoreboard bench for bram_burst_master with a behavioural BRAM and
// reference memory; random and directed bursts.
module tb_bram_burst_master;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [AW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          bram_en;
    logic          bram_wen;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_datai;
    logic [DW-1:0] bram_datao = '0;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    bram_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .bram_en(bram_en), .bram_wen(bram_wen), .bram_addr(bram_addr),
        .bram_datai(bram_datai), .bram_datao(bram_datao),
        .busy(busy), .done(done)
    );

    // Behavioural block RAM, one-cycle read latency
    logic [DW-1:0] bmem [256];
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_wen) bmem[bram_addr] <= bram_datai;
            else          bram_datao <= bmem[bram_addr];
        end
    end

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            last;
    } wexp_t;

    typedef struct {
        logic [DW-1:0] d;
        bit            last;
    } rexp_t;

    wexp_t         wq[$];
    rexp_t         rq[$];
    logic [DW-1:0] ref_mem [256];
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            n_rd_acc = 0;
    int            n_pop = 0;
    int            wr_cyc[$];
    int            pop_cyc[$];
    logic          hs_prev = 1'b0;
    logic          rv_hold = 1'b0;
    logic [DW-1:0] rd_prev = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every BRAM write and every read pop with the queues
    always @(negedge clk) begin
        wexp_t e;
        rexp_t r;
        logic  wr, pp;
        cyc++;
        if (reset) begin
            hs_prev = 1'b0;
            rv_hold = 1'b0;
        end else begin
            wr = bram_en & bram_wen;
            pp = rd_valid & rd_ready;
            if (wr || hs_prev) chk("wr_timing", 64'(wr), 64'(hs_prev));
            if (wr) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 64'(wr), 64'd0);
                end else begin
                    e = wq.pop_front();
                    chk("wr_addr", 64'(bram_addr), 64'(e.a));
                    chk("wr_data", 64'(bram_datai), 64'(e.d));
                    chk("wr_done", 64'(done), 64'(e.last));
                end
                wr_cyc.push_back(cyc);
            end
            if (bram_en && !bram_wen) n_rd_acc++;
            if (rv_hold) begin
                chk("rd_hold_valid", 64'(rd_valid), 64'd1);
                chk("rd_hold_data", 64'(rd_data), 64'(rd_prev));
            end
            if (pp) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 64'(pp), 64'd0);
                end else begin
                    r = rq.pop_front();
                    chk("rd_data", 64'(rd_data), 64'(r.d));
                    chk("rd_done", 64'(done), 64'(r.last));
                end
                pop_cyc.push_back(cyc);
                n_pop++;
            end
            if (!wr && !pp && done) chk("done_spurious", 64'(done), 64'd0);
            hs_prev = wr_valid & wr_ready;
            rv_hold = rd_valid & !rd_ready;
            rd_prev = rd_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input bit w, input logic [AW-1:0] a,
                            input logic [AW-1:0] l);
        bit hs = 0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        for (int k = 0; k < 200 && !hs; k++) begin
            @(negedge clk);
            hs = cmd_ready;
            step();
        end
        if (!hs) chk("cmd_timeout", 64'd0, 64'd1);
        cmd_valid = 1'b0;
        cmd_addr  = 8'($urandom);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int k = 0; k < 1000 && !idle; k++) begin
            @(negedge clk);
            idle = !busy;
            step();
        end
        if (!idle) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    // gmode: 0 back-to-back, 1 one on / two off, 2 random gaps
    task automatic do_write(input logic [AW-1:0] a, input logic [AW-1:0] l,
                            input int gmode, input bit fixed);
        logic [DW-1:0] data[$];
        logic [AW-1:0] ad;
        int            n = int'(l) + 1;
        for (int i = 0; i < n; i++) begin
            data.push_back(fixed ? DW'(32'hA0 + i) : $urandom);
            ad = a + AW'(i);
            ref_mem[ad] = data[i];
            wq.push_back('{ad, data[i], i == n - 1});
        end
        send_cmd(1'b1, a, l);
        for (int i = 0; i < n; i++) begin
            bit hs = 0;
            int gap;
            wr_valid = 1'b1;
            wr_data  = data[i];
            for (int k = 0; k < 200 && !hs; k++) begin
                @(negedge clk);
                hs = wr_ready;
                step();
            end
            if (!hs) chk("wr_hs_timeout", 64'd0, 64'd1);
            wr_valid = 1'b0;
            wr_data  = $urandom;
            gap = (gmode == 1) ? 2 : (gmode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (gap) step();
        end
        wait_idle();
    endtask

    // rmode: 0 rd_ready high, 1 random rd_ready, 2 stall 10 cycles first
    task automatic do_read(input logic [AW-1:0] a, input logic [AW-1:0] l,
                           input int rmode);
        int n = int'(l) + 1;
        int k = 0;
        for (int i = 0; i < n; i++) begin
            rq.push_back('{ref_mem[a + AW'(i)], i == n - 1});
        end
        wr_valid = 1'b1;
        wr_data  = $urandom;
        rd_ready = (rmode == 0) || (rmode == 1 && $urandom_range(0, 1) == 1);
        n_rd_acc = 0;
        send_cmd(1'b0, a, l);
        if (rmode == 2) begin
            repeat (10) step();
            chk("stall_reads", 64'(n_rd_acc), 64'd4);
            rd_ready = 1'b1;
        end
        while (rq.size() > 0 && k < 2000) begin
            if (rmode == 1) rd_ready = ($urandom_range(0, 2) != 0);
            step();
            k++;
        end
        if (rq.size() > 0) chk("rd_timeout", 64'(rq.size()), 64'd0);
        wr_valid = 1'b0;
        wait_idle();
        if (rmode == 2) chk("stall_total_reads", 64'(n_rd_acc), 64'd8);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_bram_en", 64'(bram_en), 64'd0);
        chk("rst_bram_wen", 64'(bram_wen), 64'd0);
        chk("rst_bram_addr", 64'(bram_addr), 64'd0);
        chk("rst_bram_datai", 64'(bram_datai), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("first_cmd_ready", 64'(cmd_ready), 64'd1);
        step();

        // Full-size burst fills every word and checks the all-ones length
        do_write(8'h37, 8'hFF, 0, 1'b0);

        wr_cyc.delete();
        do_write(8'h10, 8'd3, 0, 1'b1);
        chk("w_count", 64'(wr_cyc.size()), 64'd4);
        if (wr_cyc.size() == 4)
            chk("w_contig", 64'(wr_cyc[3] - wr_cyc[0]), 64'd3);

        pop_cyc.delete();
        do_read(8'h10, 8'd3, 0);
        chk("r_count", 64'(pop_cyc.size()), 64'd4);
        if (pop_cyc.size() == 4)
            chk("r_contig", 64'(pop_cyc[3] - pop_cyc[0]), 64'd3);

        do_read(8'h20, 8'd7, 2);
        do_write(8'hFE, 8'd3, 0, 1'b0);
        do_read(8'hFE, 8'd3, 1);
        do_write(8'h40, 8'd3, 1, 1'b0);
        do_write(8'h50, 8'd0, 0, 1'b0);
        do_read(8'h50, 8'd0, 0);

        // Abort a read burst while the third word is presented
        begin
            int k = 0;
            for (int i = 0; i < 8; i++)
                rq.push_back('{ref_mem[8'h60 + 8'(i)], i == 7});
            rd_ready = 1'b1;
            n_pop = 0;
            send_cmd(1'b0, 8'h60, 8'd7);
            while (n_pop < 2 && k < 100) begin
                step();
                k++;
            end
            chk("abort_reach", 64'(n_pop), 64'd2);
            reset = 1'b1;
            step();
            reset = 1'b0;
            rq.delete();
            @(negedge clk);
            chk("abort_rd_valid", 64'(rd_valid), 64'd0);
            chk("abort_bram_en", 64'(bram_en), 64'd0);
            chk("abort_done", 64'(done), 64'd0);
            chk("abort_busy", 64'(busy), 64'd0);
            chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
            step();
        end
        do_read(8'h10, 8'd1, 0);

        repeat (30) begin
            logic [AW-1:0] a = 8'($urandom);
            logic [AW-1:0] l = 8'($urandom_range(0, 9));
            if ($urandom_range(0, 1) == 1) do_write(a, l, 2, 1'b0);
            else                          do_read(a, l, 1);
        end

        repeat (3) step();
        chk("wq_empty", 64'(wq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
